// File: rtl/tlbread_arbiter.sv
// Two-client arbiter in front of a single TLB-read master port.
// Round-robin or fixed priority, with lock ownership for locked read sequences.
module tlbread_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        a_do,
  input  logic [1:0]  a_cpl,
  input  logic [31:0] a_address,
  input  logic [3:0]  a_length,
  input  logic [3:0]  a_length_full,
  input  logic        a_lock,
  input  logic        a_rmw,
  output logic        a_done,
  output logic        a_page_fault,
  output logic        a_ac_fault,
  output logic        a_retry,
  output logic [63:0] a_data,

  input  logic        b_do,
  input  logic [1:0]  b_cpl,
  input  logic [31:0] b_address,
  input  logic [3:0]  b_length,
  input  logic [3:0]  b_length_full,
  input  logic        b_lock,
  input  logic        b_rmw,
  output logic        b_done,
  output logic        b_page_fault,
  output logic        b_ac_fault,
  output logic        b_retry,
  output logic [63:0] b_data,

  output logic        tlbread_do,
  output logic [1:0]  tlbread_cpl,
  output logic [31:0] tlbread_address,
  output logic [3:0]  tlbread_length,
  output logic [3:0]  tlbread_length_full,
  output logic        tlbread_lock,
  output logic        tlbread_rmw,
  input  logic        tlbread_done,
  input  logic        tlbread_page_fault,
  input  logic        tlbread_ac_fault,
  input  logic        tlbread_retry,
  input  logic [63:0] tlbread_data,

  output logic [1:0]  grant_owner
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_GRANT_A = 2'b01;
  localparam logic [1:0] ST_GRANT_B = 2'b10;
  localparam logic [1:0] OWN_NONE   = 2'b00;
  localparam logic [1:0] OWN_A      = 2'b01;
  localparam logic [1:0] OWN_B      = 2'b10;
  localparam logic       LS_A       = 1'b0;
  localparam logic       LS_B       = 1'b1;

  logic [1:0] state_q, state_d;
  logic       last_served_q, last_served_d;
  logic [1:0] lock_owner_q, lock_owner_d;

  logic fault_s;
  logic term_s;
  logic owner_lock_s;
  logic grant_a_s;
  logic grant_b_s;

  assign fault_s      = tlbread_page_fault | tlbread_ac_fault | tlbread_retry;
  assign term_s       = tlbread_done | fault_s;
  assign owner_lock_s = (state_q == ST_GRANT_B) ? b_lock : a_lock;

  // Outputs are gated by rst_n so nothing leaks out while reset is asserted.
  assign grant_a_s = rst_n & (state_q == ST_GRANT_A);
  assign grant_b_s = rst_n & (state_q == ST_GRANT_B);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_served_q <= LS_B;
      lock_owner_q  <= OWN_NONE;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      lock_owner_q  <= lock_owner_d;
    end
  end

  // Next-state, round-robin history and lock ownership
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    lock_owner_d  = lock_owner_q;
    case (state_q)
      ST_IDLE: begin
        case (lock_owner_q)
          OWN_A: begin
            if (a_do) begin
              state_d = ST_GRANT_A;
            end else if (!a_lock) begin
              lock_owner_d = OWN_NONE;
            end else begin
              state_d = ST_IDLE;
            end
          end
          OWN_B: begin
            if (b_do) begin
              state_d = ST_GRANT_B;
            end else if (!b_lock) begin
              lock_owner_d = OWN_NONE;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            if (a_do && b_do) begin
              if (FIXED_PRIO || (last_served_q == LS_B)) begin
                state_d = ST_GRANT_A;
              end else begin
                state_d = ST_GRANT_B;
              end
            end else if (a_do) begin
              state_d = ST_GRANT_A;
            end else if (b_do) begin
              state_d = ST_GRANT_B;
            end else begin
              state_d = ST_IDLE;
            end
          end
        endcase
      end
      ST_GRANT_A, ST_GRANT_B: begin
        if (term_s) begin
          state_d       = ST_IDLE;
          last_served_d = (state_q == ST_GRANT_A) ? LS_A : LS_B;
          // A lock is only taken on a clean completion; any fault drops it.
          if (owner_lock_s && tlbread_done && !fault_s) begin
            lock_owner_d = (state_q == ST_GRANT_A) ? OWN_A : OWN_B;
          end else begin
            lock_owner_d = OWN_NONE;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request mux towards the master and response routing back to the clients
  always_comb begin
    grant_owner  = {grant_b_s, grant_a_s};
    tlbread_do   = (grant_a_s & a_do) | (grant_b_s & b_do);
    if (grant_b_s) begin
      tlbread_cpl         = b_cpl;
      tlbread_address     = b_address;
      tlbread_length      = b_length;
      tlbread_length_full = b_length_full;
      tlbread_lock        = b_lock;
      tlbread_rmw         = b_rmw;
    end else begin
      tlbread_cpl         = a_cpl;
      tlbread_address     = a_address;
      tlbread_length      = a_length;
      tlbread_length_full = a_length_full;
      tlbread_lock        = a_lock;
      tlbread_rmw         = a_rmw;
    end
    a_done       = grant_a_s & tlbread_done;
    a_page_fault = grant_a_s & tlbread_page_fault;
    a_ac_fault   = grant_a_s & tlbread_ac_fault;
    a_retry      = grant_a_s & tlbread_retry;
    b_done       = grant_b_s & tlbread_done;
    b_page_fault = grant_b_s & tlbread_page_fault;
    b_ac_fault   = grant_b_s & tlbread_ac_fault;
    b_retry      = grant_b_s & tlbread_retry;
    a_data       = tlbread_data;
    b_data       = tlbread_data;
  end

endmodule

// File: tb/tb_tlbread_arbiter.sv
// Directed bench for tlbread_arbiter: transaction-level model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_tlbread_arbiter;
  localparam bit FIXED_PRIO = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_do = 1'b0, b_do = 1'b0;
  logic [1:0]  a_cpl = 2'd1, b_cpl = 2'd2;
  logic [31:0] a_address = 32'h1000_0000, b_address = 32'h2000_0000;
  logic [3:0]  a_length = 4'h3, b_length = 4'h9;
  logic [3:0]  a_length_full = 4'h5, b_length_full = 4'hc;
  logic        a_lock = 1'b0, b_lock = 1'b0;
  logic        a_rmw = 1'b1, b_rmw = 1'b0;
  logic        a_done, a_page_fault, a_ac_fault, a_retry;
  logic        b_done, b_page_fault, b_ac_fault, b_retry;
  logic [63:0] a_data, b_data;
  logic        tlbread_do, tlbread_lock, tlbread_rmw;
  logic [1:0]  tlbread_cpl;
  logic [31:0] tlbread_address;
  logic [3:0]  tlbread_length, tlbread_length_full;
  logic        tlbread_done = 1'b0, tlbread_page_fault = 1'b0;
  logic        tlbread_ac_fault = 1'b0, tlbread_retry = 1'b0;
  logic [63:0] tlbread_data = 64'd0;
  logic [1:0]  grant_owner;

  int total = 0;
  int bad = 0;

  tlbread_arbiter #(.FIXED_PRIO(FIXED_PRIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_do(a_do), .a_cpl(a_cpl), .a_address(a_address), .a_length(a_length),
    .a_length_full(a_length_full), .a_lock(a_lock), .a_rmw(a_rmw),
    .a_done(a_done), .a_page_fault(a_page_fault), .a_ac_fault(a_ac_fault),
    .a_retry(a_retry), .a_data(a_data),
    .b_do(b_do), .b_cpl(b_cpl), .b_address(b_address), .b_length(b_length),
    .b_length_full(b_length_full), .b_lock(b_lock), .b_rmw(b_rmw),
    .b_done(b_done), .b_page_fault(b_page_fault), .b_ac_fault(b_ac_fault),
    .b_retry(b_retry), .b_data(b_data),
    .tlbread_do(tlbread_do), .tlbread_cpl(tlbread_cpl),
    .tlbread_address(tlbread_address), .tlbread_length(tlbread_length),
    .tlbread_length_full(tlbread_length_full), .tlbread_lock(tlbread_lock),
    .tlbread_rmw(tlbread_rmw), .tlbread_done(tlbread_done),
    .tlbread_page_fault(tlbread_page_fault), .tlbread_ac_fault(tlbread_ac_fault),
    .tlbread_retry(tlbread_retry), .tlbread_data(tlbread_data),
    .grant_owner(grant_owner)
  );

  always #5 clk = ~clk;

  // Model: owner 0 none / 1 A / 2 B; last = who was served last; lock = owning client.
  int m_owner = 0, m_last = 2, m_lock = 0;
  int n_owner, n_last, n_lock;
  logic want_a, want_b, any_term, any_fault, own_lock;
  logic started = 1'b0;

  always_comb begin
    n_owner = m_owner;
    n_last  = m_last;
    n_lock  = m_lock;
    any_fault = tlbread_page_fault | tlbread_ac_fault | tlbread_retry;
    any_term  = tlbread_done | any_fault;
    own_lock  = (m_owner == 2) ? b_lock : a_lock;
    want_a = a_do && (m_lock != 2);
    want_b = b_do && (m_lock != 1);
    if (!rst_n) begin
      n_owner = 0; n_last = 2; n_lock = 0;
    end else if (m_owner != 0) begin
      if (any_term) begin
        n_last  = m_owner;
        n_owner = 0;
        n_lock  = (own_lock && tlbread_done && !any_fault) ? m_owner : 0;
      end
    end else begin
      if (want_a && want_b) n_owner = (FIXED_PRIO || m_last == 2) ? 1 : 2;
      else if (want_a) n_owner = 1;
      else if (want_b) n_owner = 2;
      if (m_lock == 1 && !a_do && !a_lock) n_lock = 0;
      if (m_lock == 2 && !b_do && !b_lock) n_lock = 0;
    end
  end

  always @(posedge clk) begin
    m_owner <= n_owner;
    m_last  <= n_last;
    m_lock  <= n_lock;
    started <= 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : cmp
    logic [1:0]  eo;
    logic        ed;
    logic [43:0] ef;
    logic [3:0]  tf, eaf, ebf;
    if (started) begin
      eo = !rst_n ? 2'b00 : (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      ed = (eo == 2'b01) ? a_do : (eo == 2'b10) ? b_do : 1'b0;
      ef = (eo == 2'b10) ? {b_cpl, b_address, b_length, b_length_full, b_lock, b_rmw}
                         : {a_cpl, a_address, a_length, a_length_full, a_lock, a_rmw};
      tf  = {tlbread_done, tlbread_page_fault, tlbread_ac_fault, tlbread_retry};
      eaf = (eo == 2'b01) ? tf : 4'b0000;
      ebf = (eo == 2'b10) ? tf : 4'b0000;
      chk("m_owner", grant_owner, eo);
      chk("m_do", tlbread_do, ed);
      chk("m_fields", {tlbread_cpl, tlbread_address, tlbread_length, tlbread_length_full,
                       tlbread_lock, tlbread_rmw}, ef);
      chk("m_a_flags", {a_done, a_page_fault, a_ac_fault, a_retry}, eaf);
      chk("m_b_flags", {b_done, b_page_fault, b_ac_fault, b_retry}, ebf);
      chk("m_data", {a_data ^ tlbread_data} | {b_data ^ tlbread_data}, 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    tlbread_data = {$urandom, $urandom};
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_do = 1'b0; b_do = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
    tlbread_done = 1'b0; tlbread_page_fault = 1'b0;
    tlbread_ac_fault = 1'b0; tlbread_retry = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] seq [4];
    int n;

    // Tie-break after reset, terminal routing, next grant
    do_reset();
    settle();
    chk("reset_owner", grant_owner, 2'b00);
    chk("reset_do", tlbread_do, 1'b0);
    chk("reset_a_done", a_done, 1'b0);
    a_do = 1'b1; b_do = 1'b1;
    settle();
    chk("c0_no_comb_do", tlbread_do, 1'b0);
    step(); settle();
    chk("c1_owner", grant_owner, 2'b01);
    chk("c1_do", tlbread_do, 1'b1);
    chk("c1_addr", tlbread_address, 32'h1000_0000);
    step();
    step(); tlbread_done = 1'b1; settle();
    chk("c3_a_done", a_done, 1'b1);
    chk("c3_b_done", b_done, 1'b0);
    step(); tlbread_done = 1'b0; settle();
    chk("c4_owner", grant_owner, 2'b00);
    chk("c4_do", tlbread_do, 1'b0);
    step(); settle();
    chk("c5_owner", grant_owner, 2'b10);
    chk("c5_addr", tlbread_address, 32'h2000_0000);
    chk("c5_len", tlbread_length, 4'h9);
    step(); tlbread_done = 1'b1;
    step(); tlbread_done = 1'b0; a_do = 1'b0; b_do = 1'b0;

    // Continuous requests alternate A,B,A,B with an idle gap
    do_reset();
    a_do = 1'b1; b_do = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      settle();
      while (grant_owner == 2'b00 && n < 8) begin
        step(); settle(); n++;
      end
      if (grant_owner == 2'b00) begin
        total++; bad++;
        $display("FAIL rr_grant_wait: got=timeout expected=grant");
      end
      seq[k] = grant_owner;
      step();
      step(); tlbread_done = 1'b1;
      step(); tlbread_done = 1'b0; settle();
      chk("rr_gap", grant_owner, 2'b00);
    end
    chk("rr_seq0", seq[0], 2'b01);
    chk("rr_seq1", seq[1], 2'b10);
    chk("rr_seq2", seq[2], 2'b01);
    chk("rr_seq3", seq[3], 2'b10);
    a_do = 1'b0; b_do = 1'b0;

    // Lock held by A keeps B waiting until A completes unlocked
    do_reset();
    a_do = 1'b1; a_lock = 1'b1;
    step(); settle();
    chk("lk_first_a", grant_owner, 2'b01);
    step(); tlbread_done = 1'b1;
    step(); tlbread_done = 1'b0; a_do = 1'b0; b_do = 1'b1; settle();
    chk("lk_idle", grant_owner, 2'b00);
    step(); settle();
    chk("lk_b_waits1", grant_owner, 2'b00);
    step(); settle();
    chk("lk_b_waits2", grant_owner, 2'b00);
    a_do = 1'b1;
    step(); settle();
    chk("lk_second_a", grant_owner, 2'b01);
    a_lock = 1'b0;
    step(); tlbread_done = 1'b1;
    step(); tlbread_done = 1'b0; a_do = 1'b0; settle();
    chk("lk_release_idle", grant_owner, 2'b00);
    step(); settle();
    chk("lk_b_next", grant_owner, 2'b10);
    tlbread_done = 1'b1;
    step(); tlbread_done = 1'b0; b_do = 1'b0;

    // Page fault on B: routed to B only, lock not taken
    do_reset();
    b_do = 1'b1; b_lock = 1'b1;
    step(); settle();
    chk("pf_owner_b", grant_owner, 2'b10);
    tlbread_page_fault = 1'b1; settle();
    chk("pf_b_flag", b_page_fault, 1'b1);
    chk("pf_a_flag", a_page_fault, 1'b0);
    step(); tlbread_page_fault = 1'b0; a_do = 1'b1; settle();
    chk("pf_idle", grant_owner, 2'b00);
    step(); settle();
    chk("pf_no_lock_a_wins", grant_owner, 2'b01);
    tlbread_done = 1'b1; tlbread_ac_fault = 1'b1; settle();
    chk("multi_flags", {a_done, a_page_fault, a_ac_fault, a_retry}, 4'b1010);
    step(); tlbread_done = 1'b0; tlbread_ac_fault = 1'b0;
    a_do = 1'b0; b_do = 1'b0; b_lock = 1'b0;

    // Grant held with a_do dropped until retry
    do_reset();
    a_do = 1'b1;
    step(); a_do = 1'b0; b_do = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(); settle();
      chk("hold_owner", grant_owner, 2'b01);
      chk("hold_do", tlbread_do, 1'b0);
    end
    tlbread_retry = 1'b1; settle();
    chk("hold_a_retry", a_retry, 1'b1);
    chk("hold_b_retry", b_retry, 1'b0);
    step(); tlbread_retry = 1'b0; settle();
    chk("hold_idle", grant_owner, 2'b00);
    step(); settle();
    chk("hold_b_next", grant_owner, 2'b10);
    tlbread_done = 1'b1;
    step(); tlbread_done = 1'b0; b_do = 1'b0;

    // Reset mid-grant with done in the same cycle
    do_reset();
    a_do = 1'b1;
    step(); settle();
    chk("rst_grant_a", grant_owner, 2'b01);
    step(); rst_n = 1'b0; tlbread_done = 1'b1; settle();
    chk("rst_no_done_during", a_done, 1'b0);
    chk("rst_owner_during", grant_owner, 2'b00);
    step(); rst_n = 1'b1; tlbread_done = 1'b0; a_do = 1'b0; settle();
    chk("rst_idle_after", grant_owner, 2'b00);
    chk("rst_no_done_after", a_done, 1'b0);
    step(); settle();
    chk("rst_still_idle", grant_owner, 2'b00);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
